seq_scan_ctrl: RTL

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serial 4-bit pattern scanner with a match counter and run/done control
// Matches overlap; a nonzero target ends the run in DONE on the edge that reaches it.
module seq_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [3:0]       r_pattern;
  logic [CNT_W-1:0] r_target;
  logic [3:0]       r_window;
  logic [2:0]       r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_match;

  state_t           w_state_nxt;
  logic [3:0]       w_pattern_nxt;
  logic [CNT_W-1:0] w_target_nxt;
  logic [3:0]       w_window_nxt;
  logic [2:0]       w_fill_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_match_nxt;

  logic [3:0]       w_shift;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hit;

  assign w_shift   = {r_window[2:0], x};
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  // Fewer than three earlier bits means the window still holds reset zeros.
  assign w_hit     = (r_fill >= 3'd3) && (w_shift == r_pattern);

  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_target_nxt  = r_target;
    w_window_nxt  = r_window;
    w_fill_nxt    = r_fill;
    w_cnt_nxt     = r_cnt;
    w_match_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (cfg_we) begin
          w_pattern_nxt = cfg_pattern;
          w_target_nxt  = cfg_target;
        end
        if (start) begin
          w_state_nxt  = S_RUN;
          w_window_nxt = 4'b0000;
          w_fill_nxt   = 3'd0;
          w_cnt_nxt    = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (x_valid) begin
          w_window_nxt = w_shift;
          w_fill_nxt   = (r_fill == 3'd4) ? r_fill : r_fill + 3'd1;
          if (w_hit) begin
            w_match_nxt = 1'b1;
            w_cnt_nxt   = w_cnt_inc;
            if ((r_target != '0) && (w_cnt_inc == r_target)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_pattern <= 4'b0000;
      r_target  <= '0;
      r_window  <= 4'b0000;
      r_fill    <= 3'd0;
      r_cnt     <= '0;
      r_match   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pattern <= w_pattern_nxt;
      r_target  <= w_target_nxt;
      r_window  <= w_window_nxt;
      r_fill    <= w_fill_nxt;
      r_cnt     <= w_cnt_nxt;
      r_match   <= w_match_nxt;
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign state     = r_state;

endmodule
